byte_operand_fetch_stage: RTL and testbench

//   Operand-fetch pipeline stage of the 3-stage processor.

---
 rtl/byte_operand_fetch_stage.sv | 93 +++++++++
 tb/tb_byte_operand_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/byte_operand_fetch_stage.sv
// Operand-fetch stage: 4 x 8-bit register file, two read ports, valid/ready output register.
// Optional macro WB_BYPASS_EN forwards same-edge writeback data into the captured operands.
module byte_operand_fetch_stage #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rs_a,
   input  logic [ADDR_W-1:0] rs_b,
   input  logic [ADDR_W-1:0] rd,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [WIDTH-1:0]  wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  op_a,
   output logic [WIDTH-1:0]  op_b,
   output logic [ADDR_W-1:0] out_rd
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [WIDTH-1:0]  regs_q [NREG];
   logic [WIDTH-1:0]  regs_d [NREG];
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d;
   logic [WIDTH-1:0]  op_b_q, op_b_d;
   logic [ADDR_W-1:0] out_rd_q, out_rd_d;
   logic [WIDTH-1:0]  rd_val_a, rd_val_b;
   logic              accept;

   // Read ports, optionally forwarding the writeback landing on this edge
   always_comb begin
`ifdef WB_BYPASS_EN
      rd_val_a = (wb_en && (wb_addr == rs_a)) ? wb_data : regs_q[rs_a];
      rd_val_b = (wb_en && (wb_addr == rs_b)) ? wb_data : regs_q[rs_b];
`else
      rd_val_a = regs_q[rs_a];
      rd_val_b = regs_q[rs_b];
`endif
   end

   // Next-state: writeback is independent of the handshake; output register holds on stall
   always_comb begin
      regs_d      = regs_q;
      out_valid_d = out_valid_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      out_rd_d    = out_rd_q;
      in_ready    = !out_valid_q || out_ready;
      accept      = in_valid && in_ready;

      if (wb_en) begin
         regs_d[wb_addr] = wb_data;
      end

      if (accept) begin
         out_valid_d = 1'b1;
         op_a_d      = rd_val_a;
         op_b_d      = rd_val_b;
         out_rd_d    = rd;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         out_rd_q    <= '0;
      end else begin
         regs_q      <= regs_d;
         out_valid_q <= out_valid_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         out_rd_q    <= out_rd_d;
      end
   end

   assign out_valid = out_valid_q;
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_byte_operand_fetch_stage.sv
// Self-checking bench for byte_operand_fetch_stage: directed scenarios then random traffic
// checked against an array-based reference model.
module tb_byte_operand_fetch_stage;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, wb_en, out_valid, out_ready;
   logic [1:0] rs_a, rs_b, rd, wb_addr, out_rd;
   logic [7:0] wb_data, op_a, op_b;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] m_regs [4];
   bit         m_valid;
   bit         m_known = 1'b0;
   bit         m_ops_known = 1'b0;
   logic [7:0] m_a, m_b;
   logic [1:0] m_rd;

   always #5 clk = ~clk;

   byte_operand_fetch_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
      .op_a(op_a), .op_b(op_b), .out_rd(out_rd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 0; in_valid = 0; rs_a = 0; rs_b = 0; rd = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
   endtask

   // One clock: check in_ready, advance model from the applied inputs, check outputs after edge
   task automatic tick();
      bit acc;
      #1;
      if (m_known) chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 8'h00;
         m_valid = 0; m_a = 0; m_b = 0; m_rd = 0;
         m_known = 1; m_ops_known = 1;
      end else if (m_known) begin
         acc = in_valid && (!m_valid || out_ready);
         if (acc) begin
            m_a = (BYPASS && wb_en && wb_addr == rs_a) ? wb_data : m_regs[rs_a];
            m_b = (BYPASS && wb_en && wb_addr == rs_b) ? wb_data : m_regs[rs_b];
            m_rd = rd; m_valid = 1; m_ops_known = 1;
         end else if (out_ready) begin
            m_valid = 0;
         end
         if (wb_en) m_regs[wb_addr] = wb_data;
      end
      @(posedge clk);
      #1;
      if (m_known) begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid || (m_ops_known && rst)) begin
            chk("op_a", 32'(op_a), 32'(m_a));
            chk("op_b", 32'(op_b), 32'(m_b));
            chk("out_rd", 32'(out_rd), 32'(m_rd));
         end
      end
   endtask

   task automatic req(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
      in_valid = 1; rs_a = a; rs_b = b; rd = d;
   endtask

   task automatic read_all();
      for (int i = 0; i < 4; i++) begin
         idle();
         req(2'(i), 2'(3 - i), 2'(i));
         tick();
      end
      idle();
      tick();
   endtask

   initial begin
      idle();
      // 1 reset with competing writeback and request
      rst = 1; wb_en = 1; wb_addr = 2; wb_data = 8'h5A; req(2, 2, 3);
      tick();
      tick();
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_op_a", 32'(op_a), 32'd0);
      read_all();

      // 2 write/read
      idle(); wb_en = 1; wb_addr = 2; wb_data = 8'hA5; tick();
      wb_addr = 3; wb_data = 8'h3C; tick();
      idle(); req(2, 3, 1); tick();
      chk("wr_op_a", 32'(op_a), 32'hA5);
      chk("wr_op_b", 32'(op_b), 32'h3C);

      // 3 stall with writeback and pending request
      idle(); out_ready = 0; tick();
      wb_en = 1; wb_addr = 2; wb_data = 8'hFF; req(0, 2, 2); tick();
      wb_en = 0; tick();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_op_a", 32'(op_a), 32'hA5);
      out_ready = 1; tick();
      chk("release_op_b", 32'(op_b), 32'hFF);
      idle(); tick();

      // 4 same-edge hazard
      wb_en = 1; wb_addr = 1; wb_data = 8'h11; tick();
      wb_data = 8'h77; req(1, 1, 0); tick();
      chk("hazard_op_a", 32'(op_a), BYPASS ? 32'h77 : 32'h11);
      idle(); req(1, 1, 0); tick();
      chk("hazard_reg", 32'(op_b), 32'h77);

      // 5 throughput
      idle();
      for (int i = 0; i < 8; i++) begin
         wb_en = 1; wb_addr = 2'($urandom); wb_data = 8'($urandom);
         req(2'($urandom), 2'($urandom), 2'($urandom));
         tick();
      end
      idle(); tick();

      // 6 mid-op reset during stall
      req(2, 3, 3); tick();
      idle(); out_ready = 0; tick();
      rst = 1; tick();
      rst = 0; tick();
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      read_all();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 59) == 0);
         in_valid  = $urandom_range(0, 1);
         rs_a      = 2'($urandom); rs_b = 2'($urandom); rd = 2'($urandom);
         wb_en     = $urandom_range(0, 1);
         wb_addr   = 2'($urandom); wb_data = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
